instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Sits directly upstream of the single-cycle core.
- Converts the core's combinational `pc` → `instruction` lookup into a req/ack handshake with a variable-latency instruction memory.
- Holds one fetched word in a tagged buffer and drives `wait_sig`, which tells the core to hold its state while the instruction for the current pc is not yet available.
- Reports fetch faults (bus error, timeout, misaligned pc) to the core's exception logic.

Parameters:
- RST_PC_ADDRESS, 32'h0: reset value of mem_addr; must match the core's reset pc.
- NOP_INSTR, 32'h00000013: word driven on `instruction` while `wait_sig`=1 (addi x0,x0,0).
- TIMEOUT_CYCLES, 255: maximum cycles in BUSY without mem_ack before a fault; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc  input  32  current program counter from the core.
- fence_i  input  1  single-cycle pulse; invalidates the buffer.
- instruction  output  32  instruction word for `pc`; equals NOP_INSTR when not valid.
- wait_sig  output  1  1 = instruction not valid for `pc`, core must stall.
- mem_req  output  1  request to instruction memory, registered.
- mem_addr  output  32  word address of the request, registered.
- mem_ack  input  1  response valid; completes the request in the same cycle.
- mem_rdata  input  32  read data, sampled when mem_ack=1.
- mem_err  input  1  bus error, qualified by mem_ack.
- fetch_fault  output  1  1 while in FAULT.
- fetch_fault_addr  output  32  pc of the faulting fetch; holds its value until the next fault.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, buf_valid=0, mem_req=0.
  - mem_addr=RST_PC_ADDRESS, fetch_fault=0, fetch_fault_addr=0, timeout counter=0.
- Hit (combinational):
  - hit = buf_valid && buf_addr==pc && state!=FAULT.
  - On hit: instruction=buf_data, wait_sig=0.
  - Otherwise: instruction=NOP_INSTR, wait_sig=1.
- State IDLE:
  - hit → stay in IDLE.
  - Miss with pc[1:0]!=0 → FAULT; latch fetch_fault_addr=pc; no request is issued.
  - Miss with pc aligned → BUSY; on the next edge mem_req=1, mem_addr=pc, req_addr=pc, counter cleared.
- State BUSY:
  - mem_req and mem_addr stay stable until mem_ack. A request is never withdrawn, including when pc changes.
  - mem_ack && !mem_err → buf_addr=req_addr, buf_data=mem_rdata, buf_valid=1, mem_req=0, next state IDLE.
  - mem_ack && mem_err → buf_valid=0, latch fetch_fault_addr=req_addr, next state FAULT.
  - Counter increments every BUSY cycle without ack. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 without ack: fault as for mem_err, and mem_req drops.
- State FAULT:
  - fetch_fault=1, wait_sig=1.
  - Exit to IDLE when pc != fetch_fault_addr (trap redirect) or on fence_i.
- Latency:
  - Miss detected in cycle 0 → mem_req high in cycle 1.
  - Zero-wait ack in cycle 1 → wait_sig=0 in cycle 2.
  - Minimum miss penalty is 2 stall cycles.
  - Back-to-back misses: IDLE re-evaluates the cycle after the ack, so there is one idle cycle between requests.
- Redirect mid-fetch: the in-flight response is written to the buffer under req_addr, which is then a miss for the new pc. A new request is issued from IDLE.
- fence_i:
  - Clears buf_valid.
  - In BUSY: sets a discard flag, and the response is dropped when acked; errors on a discarded response do not fault.
  - Coincident with mem_ack: the discard wins.
- Reset mid-transfer: mem_req drops asynchronously. The memory side is required to abandon the outstanding request.

Decomposition:
- Shared package core_pkg holds:
  - fetch FSM state encoding (IDLE=2'd0, BUSY=2'd1, FAULT=2'd2);
  - the NOP_INSTR constant;
  - the exception code value for instruction access fault (1) and instruction misaligned (0), which the core uses with fetch_fault.
- One natural sub-module: fetch_line_buffer, the tagged one-entry buffer (valid/addr/data, write, invalidate, hit compare).

Test Plan:
- Reset, pc=0x0, memory acks with zero wait, rdata=0x00500093 → mem_req in cycle 1 with mem_addr=0x0; wait_sig=0 and instruction=0x00500093 in cycle 2.
- pc=0x4, ack delayed 5 cycles → mem_req/mem_addr=0x4 stable for 5 cycles; wait_sig=1 throughout with instruction=0x00000013; hit in the cycle after ack.
- pc changes 0x8→0x100 while BUSY on 0x8 → no new request until ack of 0x8; then request 0x100; buffer tag becomes 0x100.
- Ack with mem_err=1 for pc=0x20 → fetch_fault=1 and fetch_fault_addr=0x20; pc→0x80 then clears the fault and issues a request for 0x80.
- pc=0x6 → FAULT without mem_req; fetch_fault_addr=0x6. Separately, TIMEOUT_CYCLES=4 with no ack → fault after 4 BUSY cycles and mem_req=0.
- fence_i pulse during BUSY on 0x10 → response discarded, buf_valid=0, refetch of 0x10 issued; rst_n low mid-BUSY → mem_req=0 immediately.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: fetch FSM encoding, NOP word, fetch exception codes.
package core_pkg;

    localparam int unsigned XLEN = 32;

    // Fetch FSM state encoding
    typedef enum logic [1:0] {
        FETCH_IDLE  = 2'd0,
        FETCH_BUSY  = 2'd1,
        FETCH_FAULT = 2'd2
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // Exception codes the core pairs with fetch_fault
    localparam logic [3:0] EXC_INSTR_MISALIGNED   = 4'd0;
    localparam logic [3:0] EXC_INSTR_ACCESS_FAULT = 4'd1;

    // One buffered instruction word and its tag
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_line_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// Tagged one-entry instruction buffer with write, invalidate and hit compare.
module fetch_line_buffer
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            inv,
    input  logic [XLEN-1:0] lookup_addr,
    output logic            hit_c,
    output logic [XLEN-1:0] rd_data
);

    logic        valid_q;
    fetch_line_t line_q;

    // Entry storage; invalidate takes priority over a same-cycle write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            line_q  <= '0;
        end else if (inv) begin
            valid_q <= 1'b0;
        end else if (wr_en) begin
            valid_q <= 1'b1;
            line_q  <= '{addr: wr_addr, data: wr_data};
        end
    end

    assign hit_c   = valid_q && (line_q.addr == lookup_addr);
    assign rd_data = line_q.data;

endmodule

// File: rtl/instr_fetch_unit.sv
// Turns the core's combinational pc->instruction lookup into a req/ack fetch
// from variable-latency memory, stalling the core via wait_sig until ready.
module instr_fetch_unit #(
    parameter logic [31:0] RST_PC_ADDRESS = 32'h0,
    parameter logic [31:0] NOP_INSTR      = core_pkg::NOP_INSTR,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        fence_i,
    output logic [31:0] instruction,
    output logic        wait_sig,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        fetch_fault,
    output logic [31:0] fetch_fault_addr
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    core_pkg::fetch_state_e state_q, state_d;

    logic             mem_req_d;
    logic [31:0]      mem_addr_d;
    logic [31:0]      fault_addr_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             buf_wr_c;
    logic             buf_inv_c;
    logic             buf_hit_c;
    logic [31:0]      buf_data;
    logic             hit_c;
    logic             timeout_c;

    fetch_line_buffer u_line_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (buf_wr_c),
        .wr_addr     (mem_addr),
        .wr_data     (mem_rdata),
        .inv         (buf_inv_c),
        .lookup_addr (pc),
        .hit_c       (buf_hit_c),
        .rd_data     (buf_data)
    );

    // Buffer contents are never presented while a fault is pending
    assign hit_c       = buf_hit_c && (state_q != core_pkg::FETCH_FAULT);
    assign instruction = hit_c ? buf_data : NOP_INSTR;
    assign wait_sig    = !hit_c;
    assign timeout_c   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    // Next-state and request control
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        fault_addr_d = fetch_fault_addr;
        discard_d    = discard_q;
        cnt_d        = cnt_q;
        buf_wr_c     = 1'b0;
        buf_inv_c    = fence_i;

        case (state_q)
            core_pkg::FETCH_IDLE: begin
                if (!hit_c) begin
                    if (pc[1:0] != 2'b00) begin
                        state_d      = core_pkg::FETCH_FAULT;
                        fault_addr_d = pc;
                    end else begin
                        state_d    = core_pkg::FETCH_BUSY;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc;
                        cnt_d      = '0;
                        discard_d  = 1'b0;
                    end
                end
            end

            core_pkg::FETCH_BUSY: begin
                if (fence_i) begin
                    discard_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d   = core_pkg::FETCH_IDLE;
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    discard_d = 1'b0;
                    // A discarded response is dropped, including its error
                    if (!(discard_q || fence_i)) begin
                        if (mem_err) begin
                            buf_inv_c    = 1'b1;
                            fault_addr_d = mem_addr;
                            state_d      = core_pkg::FETCH_FAULT;
                        end else begin
                            buf_wr_c = 1'b1;
                        end
                    end
                end else if (timeout_c) begin
                    state_d      = core_pkg::FETCH_FAULT;
                    mem_req_d    = 1'b0;
                    buf_inv_c    = 1'b1;
                    fault_addr_d = mem_addr;
                    cnt_d        = '0;
                    discard_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            core_pkg::FETCH_FAULT: begin
                // Leave on trap redirect or explicit fence
                if ((pc != fetch_fault_addr) || fence_i) begin
                    state_d = core_pkg::FETCH_IDLE;
                end
            end

            default: begin
                state_d = core_pkg::FETCH_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= core_pkg::FETCH_IDLE;
            mem_req          <= 1'b0;
            mem_addr         <= RST_PC_ADDRESS;
            fetch_fault      <= 1'b0;
            fetch_fault_addr <= '0;
            discard_q        <= 1'b0;
            cnt_q            <= '0;
        end else begin
            state_q          <= state_d;
            mem_req          <= mem_req_d;
            mem_addr         <= mem_addr_d;
            fetch_fault      <= (state_d == core_pkg::FETCH_FAULT);
            fetch_fault_addr <= fault_addr_d;
            discard_q        <= discard_d;
            cnt_q            <= cnt_d;
        end
    end

endmodule
